uart_tx_sched: RTL and testbench

Transmit sequencer and baud-rate configuration owner for the UART. It consumes the 4x-oversampled `baudtick` from the baud generator and drives that generator's 2-bit rate select. It accepts bytes over a valid/ready handshake and shifts them out on `txd` as 8 data bits, no parity, STOP_BITS stop bits, LSB first. Rate changes requested by software are held pending and only reach the generator between frames, so a frame is never split across two rates.

---
 rtl/uart_tx_sched_if.sv | 19 +
 rtl/uart_tx_sched.sv | 145 ++++++++++++++
 tb/tb_uart_tx_sched.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_sched_if.sv
// Byte handshake between the UART client
// and the transmit sequencer.
interface uart_tx_sched_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_sched.sv
// UART transmit sequencer (8N1/8N2) that also owns
// the baud generator rate select, changed only between frames.
module uart_tx_sched #(
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              baudtick,
  output logic [1:0]        baudtick_ctrl,
  input  logic [1:0]        baud_sel_in,
  input  logic              baud_sel_we,
  output logic              baud_pending,
  uart_tx_sched_if.slave    tx,
  output logic              txd,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    START,
    DATA,
    STOP
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic       stop_q, stop_d;
  logic [7:0] shift_q, shift_d;
  logic [1:0] pend_q, pend_d;
  logic       pending_q, pending_d;
  logic [1:0] ctrl_q, ctrl_d;
  logic       txd_q, txd_d;
  logic       busy_q, busy_d;
  logic       ready;
  logic       bit_end;

  assign ready = !rst && (state_q == IDLE) && !pending_q;
  assign bit_end = baudtick && (tick_q == 2'd3);

  assign tx.tx_ready    = ready;
  assign txd            = txd_q;
  assign busy           = busy_q;
  assign baud_pending   = pending_q;
  assign baudtick_ctrl  = ctrl_q;

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    stop_d    = stop_q;
    shift_d   = shift_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    ctrl_d    = ctrl_q;
    txd_d     = txd_q;
    busy_d    = busy_q;

    // A fresh write outranks applying the older one
    if (baud_sel_we) begin
      pend_d    = baud_sel_in;
      pending_d = 1'b1;
    end else if (state_q == IDLE && pending_q) begin
      ctrl_d    = pend_q;
      pending_d = 1'b0;
    end

    if (state_q != IDLE && state_q != ALIGN && baudtick)
      tick_d = tick_q + 2'd1;

    unique case (state_q)
      IDLE: begin
        if (tx.tx_valid && ready) begin
          shift_d = tx.tx_data;
          busy_d  = 1'b1;
          state_d = ALIGN;
        end
      end
      ALIGN: begin
        if (baudtick) begin
          txd_d   = 1'b0;
          tick_d  = 2'd0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          txd_d   = shift_q[0];
          bit_d   = 3'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          txd_d   = shift_q[1];
          if (bit_q == 3'd7) begin
            txd_d   = 1'b1;
            stop_d  = 1'b0;
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          stop_d = stop_q + 1'b1;
          if (stop_q == 1'(STOP_BITS - 1)) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tick_q    <= 2'd0;
      bit_q     <= 3'd0;
      stop_q    <= 1'b0;
      shift_q   <= 8'd0;
      pend_q    <= 2'd0;
      pending_q <= 1'b0;
      ctrl_q    <= 2'd0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      stop_q    <= stop_d;
      shift_q   <= shift_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      ctrl_q    <= ctrl_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: one instance with
// one stop bit, one with two, sharing clock and baudtick.
module tb_uart_tx_sched;

  typedef struct {
    int         inst;
    logic [7:0] data;
    int         len;
    logic [1:0] ctrl;
    int         max_gap;
  } frame_t;

  frame_t exp_q[$];

  logic       clk;
  logic       rst;
  logic       baudtick;
  logic       tick_en;
  logic [1:0] sel;
  logic [1:0] we_w;
  logic [1:0] txd_w;
  logic [1:0] busy_w;
  logic [1:0] pend_w;
  logic [1:0] ctrl_w [2];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int div = 0;

  uart_tx_sched_if if1 ();
  uart_tx_sched_if if2 ();

  uart_tx_sched #(.STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .baudtick(baudtick),
    .baudtick_ctrl(ctrl_w[0]),
    .baud_sel_in(sel), .baud_sel_we(we_w[0]),
    .baud_pending(pend_w[0]), .tx(if1),
    .txd(txd_w[0]), .busy(busy_w[0])
  );

  uart_tx_sched #(.STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .baudtick(baudtick),
    .baudtick_ctrl(ctrl_w[1]),
    .baud_sel_in(sel), .baud_sel_we(we_w[1]),
    .baud_pending(pend_w[1]), .tx(if2),
    .txd(txd_w[1]), .busy(busy_w[1])
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // baudtick: one clk wide, every 5 clk
  initial begin
    baudtick = 0;
    forever begin
      @(posedge clk);
      #1;
      div = (div == 4) ? 0 : div + 1;
      baudtick = tick_en && (div == 4);
    end
  end

  initial forever begin
    @(negedge clk);
    if (if1.tx_valid && if1.tx_ready) acc_cnt++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_mon
    initial begin : mon
      bit         act;
      int         cnt, idx, gap, end_cyc;
      logic       prev;
      logic [7:0] rx;
      logic [1:0] ctrl0;
      bit         bad_edge, bad_start, bad_stop, ctrl_chg;
      frame_t     e;
      act = 0;
      prev = 1'b1;
      end_cyc = -1000;
      forever begin
        @(negedge clk);
        if (rst) begin
          act = 0;
        end else if (!act) begin
          if (prev === 1'b1 && txd_w[g] === 1'b0) begin
            act = 1; cnt = 0; rx = 0;
            bad_edge = 0; bad_start = 0;
            bad_stop = 0; ctrl_chg = 0;
            ctrl0 = ctrl_w[g];
            gap = cyc - end_cyc;
          end
        end else begin
          cnt++;
          if (txd_w[g] !== prev && (cnt % 20) != 0)
            bad_edge = 1;
          if (ctrl_w[g] !== ctrl0) ctrl_chg = 1;
          if ((cnt % 20) == 10) begin
            idx = cnt / 20;
            if (idx == 0) bad_start = (txd_w[g] !== 1'b0);
            else if (idx <= 8) rx[idx-1] = txd_w[g];
            else if (txd_w[g] !== 1'b1) bad_stop = 1;
          end
          if (busy_w[g] === 1'b0) begin
            act = 0;
            end_cyc = cyc;
            if (exp_q.size() == 0) begin
              chk("unexpected_frame", 1, 0);
            end else begin
              e = exp_q.pop_front();
              chk("frame_inst", g, e.inst);
              chk("frame_data", rx, e.data);
              chk("frame_len", cnt, e.len);
              chk("frame_ctrl", ctrl0, e.ctrl);
              chk("ctrl_stable", ctrl_chg, 0);
              chk("bit_edges", bad_edge, 0);
              chk("start_bit", bad_start, 0);
              chk("stop_bits", bad_stop, 0);
              if (e.max_gap > 0) begin
                chk("b2b_gap_ok",
                    (gap >= 1 && gap <= e.max_gap), 1);
              end
            end
          end else if (cnt > 600) begin
            act = 0;
            chk("frame_timeout", cnt, 0);
          end
        end
        prev = txd_w[g];
      end
    end
  end

  function automatic logic rdy(input int i);
    return (i == 0) ? if1.tx_ready : if2.tx_ready;
  endfunction

  task automatic set_tx(input int i, input logic v,
                        input logic [7:0] d);
    if (i == 0) begin
      if1.tx_valid = v; if1.tx_data = d;
    end else begin
      if2.tx_valid = v; if2.tx_data = d;
    end
  endtask

  task automatic send(input int i, input logic [7:0] d,
                      input int len, input logic [1:0] c,
                      input int max_gap, input bit keep);
    frame_t e;
    bit ok;
    @(posedge clk);
    #1;
    if (len > 0) begin
      e.inst = i; e.data = d; e.len = len;
      e.ctrl = c; e.max_gap = max_gap;
      exp_q.push_back(e);
    end
    set_tx(i, 1'b1, d);
    ok = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (rdy(i)) begin ok = 1; break; end
    end
    if (!ok) chk("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!keep) set_tx(i, 1'b0, d);
  endtask

  task automatic wait_idle(input int i);
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (busy_w[i] === 1'b0) return;
    end
    chk("busy_timeout", 1, 0);
  endtask

  task automatic wr(input int i, input logic [1:0] c);
    @(posedge clk);
    #1;
    sel = c;
    we_w[i] = 1'b1;
    @(posedge clk);
    #1;
    we_w[i] = 1'b0;
  endtask

  initial begin
    int a0, viol, n;
    rst = 1; tick_en = 1; sel = 0; we_w = 0;
    set_tx(0, 1'b0, 8'h00);
    set_tx(1, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_txd", txd_w[0], 1);
    chk("rst_busy", busy_w[0], 0);
    chk("rst_ready", if1.tx_ready, 0);
    chk("rst_pend", pend_w[0], 0);
    chk("rst_ctrl", ctrl_w[0], 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("idle_ready", if1.tx_ready, 1);

    send(0, 8'hA5, 200, 2'd0, 0, 0);
    wait_idle(0);

    a0 = acc_cnt;
    send(0, 8'h00, 200, 2'd0, 0, 1);
    send(0, 8'hFF, 200, 2'd0, 5, 0);
    wait_idle(0);
    chk("b2b_accepts", acc_cnt - a0, 2);

    send(0, 8'h5A, 200, 2'd0, 0, 0);
    repeat (50) @(posedge clk);
    wr(0, 2'd3);
    @(negedge clk);
    chk("mid_pend", pend_w[0], 1);
    chk("mid_ctrl_hold", ctrl_w[0], 0);
    wait_idle(0);
    chk("idle_ctrl_old", ctrl_w[0], 0);
    chk("apply_ready_low", if1.tx_ready, 0);
    chk("apply_pend", pend_w[0], 1);
    @(negedge clk);
    chk("apply_ctrl", ctrl_w[0], 3);
    chk("apply_pend_clr", pend_w[0], 0);
    chk("apply_ready_up", if1.tx_ready, 1);

    send(0, 8'h33, 200, 2'd3, 0, 0);
    repeat (30) @(posedge clk);
    wr(0, 2'd2);
    repeat (40) @(posedge clk);
    wr(0, 2'd1);
    wait_idle(0);
    chk("two_wr_hold", ctrl_w[0], 3);
    @(negedge clk);
    chk("two_wr_last", ctrl_w[0], 1);

    @(posedge clk);
    #1;
    begin
      frame_t e;
      e.inst = 1; e.data = 8'hC3; e.len = 220;
      e.ctrl = 2'd0; e.max_gap = 0;
      exp_q.push_back(e);
    end
    set_tx(1, 1'b1, 8'hC3);
    sel = 2'd2;
    we_w[1] = 1'b1;
    @(negedge clk);
    chk("wa_ready", if2.tx_ready, 1);
    @(posedge clk);
    #1;
    set_tx(1, 1'b0, 8'hC3);
    we_w[1] = 1'b0;
    @(negedge clk);
    chk("wa_pend", pend_w[1], 1);
    chk("wa_busy", busy_w[1], 1);
    wait_idle(1);
    chk("wa_ctrl_old", ctrl_w[1], 0);
    @(negedge clk);
    chk("wa_ctrl_new", ctrl_w[1], 2);

    send(0, 8'h96, 0, 2'd1, 0, 0);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (txd_w[0] === 1'b0) break;
    end
    repeat (84) @(negedge clk);
    wr(0, 2'd2);
    rst = 1;
    @(negedge clk);
    chk("pre_rst_pend", pend_w[0], 1);
    chk("pre_rst_busy", busy_w[0], 1);
    @(negedge clk);
    chk("post_rst_txd", txd_w[0], 1);
    chk("post_rst_busy", busy_w[0], 0);
    chk("post_rst_ctrl", ctrl_w[0], 0);
    chk("post_rst_pend", pend_w[0], 0);
    @(posedge clk);
    #1 rst = 0;
    send(0, 8'h3C, 200, 2'd0, 0, 0);
    wait_idle(0);

    tick_en = 0;
    send(0, 8'h81, 200, 2'd0, 0, 0);
    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (txd_w[0] !== 1'b1 || busy_w[0] !== 1'b1) viol++;
    end
    chk("align_hold", viol, 0);
    tick_en = 1;
    n = 0;
    while (n < 10 && txd_w[0] !== 1'b0) begin
      @(negedge clk);
      n++;
    end
    chk("align_first_tick", (n >= 1 && n <= 6), 1);
    wait_idle(0);

    for (int k = 0; k < 3000; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
